// File: rtl/ltc233x_pkg.sv
// ltc233x_pkg: shared tags, FSM states and CRC helpers for the LTC233x multi-channel readout.
// Build option: LTC233X_FRAME_CRC_EN adds the CRC trailer state and the CRC update function.
package ltc233x_pkg;

    // Tags placed in bits [31:28] of every output word
    localparam logic [3:0] TAG_TS_LO = 4'hA;
    localparam logic [3:0] TAG_TS_HI = 4'hB;
    localparam logic [3:0] TAG_DATA  = 4'hD;
    localparam logic [3:0] TAG_CRC   = 4'hC;

    // CRC-16-CCITT
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

`ifdef LTC233X_FRAME_CRC_EN
    typedef enum logic [2:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_CAPTURE, ST_CRC} state_t;

    // Folds one 24-bit data field into the running CRC, MSB first
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [23:0] data);
        logic [15:0] r;
        r = crc;
        for (int i = 23; i >= 0; i--)
            r = (r[15] ^ data[i]) ? ({r[14:0], 1'b0} ^ CRC_POLY) : {r[14:0], 1'b0};
        return r;
    endfunction
`else
    typedef enum logic [1:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_CAPTURE} state_t;
`endif

endpackage

// File: rtl/ltc233x_multi_read_fifo.sv
// ltc_sync_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Ports: clk, reset (async, active-high); wr_en/wr_data push; rd_en pops the head;
//        rd_data shows the head (0 while empty); empty flag; count = words stored.
module ltc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && ((count != (AW+1)'(DEPTH)) || pop);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ltc233x_multi_read.sv
// ltc233x_multi_read: captures N_CH-channel LTC233x DDR frames, timestamps them and streams 32-bit words.
// Ports: clk, reset (async, active-high); enable gates new frames; ts_reset rising edge zeroes the
//        timestamp; cnv_in/scko_in/sdo_in are the asynchronous ADC pins; m_tdata/m_tvalid/m_tready
//        form the output stream; overflow_cnt/err_cnt count dropped/truncated frames; busy flags capture.
// Build option: LTC233X_FRAME_CRC_EN appends a CRC-16 trailer word to every complete frame.
module ltc233x_multi_read
    import ltc233x_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int PKT_BITS    = 24,
    parameter int TS_WIDTH    = 56,
    parameter int BUF_DEPTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ts_reset,
    input  logic        cnv_in,
    input  logic        scko_in,
    input  logic        sdo_in,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] overflow_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);
`ifdef LTC233X_FRAME_CRC_EN
    localparam int RESERVE = N_CH + 3;
`else
    localparam int RESERVE = N_CH + 2;
`endif
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    logic [SYNC_STAGES-1:0] cnv_sync_q, cnv_sync_d, scko_sync_q, scko_sync_d, sdo_sync_q, sdo_sync_d;
    logic                   cnv_prev_q, cnv_prev_d, scko_prev_q, scko_prev_d;
    logic                   ts_reset_prev_q, ts_reset_prev_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [55:0]            t_q, t_d;
    state_t                 state_q, state_d;
    logic [PKT_BITS-1:0]    sh_q, sh_d, pkt;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [3:0]             ch_q, ch_d;
    logic [15:0]            overflow_cnt_q, overflow_cnt_d, err_cnt_q, err_cnt_d;
    logic [23:0]            data24;
    logic                   cnv_rise, scko_edge, sdo_s, room, wr_en;
    logic [31:0]            wr_data;
    logic [CW-1:0]          fifo_cnt;
    logic                   fifo_empty;
`ifdef LTC233X_FRAME_CRC_EN
    logic [15:0]            crc_q, crc_d;
`endif

    assign cnv_rise  = cnv_sync_q[SYNC_STAGES-1] && !cnv_prev_q;
    assign scko_edge = scko_sync_q[SYNC_STAGES-1] ^ scko_prev_q;
    assign sdo_s     = sdo_sync_q[SYNC_STAGES-1];
    assign pkt       = {sh_q[PKT_BITS-2:0], sdo_s};
    assign data24    = 24'(pkt) << (24 - PKT_BITS);
    assign busy      = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_CAPTURE);

    // A CRC word being written this cycle still occupies its reserved slot
`ifdef LTC233X_FRAME_CRC_EN
    assign room = (int'(fifo_cnt) + ((state_q == ST_CRC) ? 1 : 0) + RESERVE) <= BUF_DEPTH;
`else
    assign room = (int'(fifo_cnt) + RESERVE) <= BUF_DEPTH;
`endif

    always_comb begin
        cnv_sync_d      = {cnv_sync_q[SYNC_STAGES-2:0], cnv_in};
        scko_sync_d     = {scko_sync_q[SYNC_STAGES-2:0], scko_in};
        sdo_sync_d      = {sdo_sync_q[SYNC_STAGES-2:0], sdo_in};
        cnv_prev_d      = cnv_sync_q[SYNC_STAGES-1];
        scko_prev_d     = scko_sync_q[SYNC_STAGES-1];
        ts_reset_prev_d = ts_reset;
        ts_d            = (ts_reset && !ts_reset_prev_q) ? '0 : ts_q + TS_ONE;
        state_d         = state_q;
        t_d             = t_q;
        sh_d            = sh_q;
        bit_cnt_d       = bit_cnt_q;
        ch_d            = ch_q;
        overflow_cnt_d  = overflow_cnt_q;
        err_cnt_d       = err_cnt_q;
`ifdef LTC233X_FRAME_CRC_EN
        crc_d           = crc_q;
`endif
        wr_en           = 1'b0;
        wr_data         = '0;
        case (state_q)
            ST_HDR0: begin
                wr_en   = 1'b1;
                wr_data = {TAG_TS_LO, t_q[27:0]};
                state_d = ST_HDR1;
            end
            ST_HDR1: begin
                wr_en   = 1'b1;
                wr_data = {TAG_TS_HI, t_q[55:28]};
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (scko_edge) begin
                    sh_d      = pkt;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(PKT_BITS - 1)) begin
                        wr_en     = 1'b1;
                        wr_data   = {TAG_DATA, ch_q, data24};
                        bit_cnt_d = '0;
                        ch_d      = ch_q + 4'd1;
`ifdef LTC233X_FRAME_CRC_EN
                        crc_d     = crc16_upd(crc_q, data24);
                        if (ch_q == 4'(N_CH - 1)) state_d = ST_CRC;
`else
                        if (ch_q == 4'(N_CH - 1)) state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef LTC233X_FRAME_CRC_EN
            ST_CRC: begin
                wr_en   = 1'b1;
                wr_data = {TAG_CRC, 12'h0, crc_q};
                state_d = ST_IDLE;
            end
`endif
            default: ;
        endcase
        // cnv overrides everything: abort a frame in flight, then treat the edge as a fresh IDLE edge
        if (cnv_rise) begin
            if (busy) begin
                err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                wr_en     = 1'b0;
                state_d   = ST_IDLE;
            end
            if (enable && room) begin
                state_d   = ST_HDR0;
                t_d       = 56'(ts_q);
                ch_d      = '0;
                bit_cnt_d = '0;
`ifdef LTC233X_FRAME_CRC_EN
                crc_d     = CRC_INIT;
`endif
            end else if (enable) begin
                overflow_cnt_d = (overflow_cnt_q == 16'hFFFF) ? overflow_cnt_q : overflow_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnv_sync_q      <= '0;
            scko_sync_q     <= '0;
            sdo_sync_q      <= '0;
            cnv_prev_q      <= 1'b0;
            scko_prev_q     <= 1'b0;
            ts_reset_prev_q <= 1'b0;
            ts_q            <= '0;
            t_q             <= '0;
            state_q         <= ST_IDLE;
            sh_q            <= '0;
            bit_cnt_q       <= '0;
            ch_q            <= '0;
            overflow_cnt_q  <= '0;
            err_cnt_q       <= '0;
`ifdef LTC233X_FRAME_CRC_EN
            crc_q           <= CRC_INIT;
`endif
        end else begin
            cnv_sync_q      <= cnv_sync_d;
            scko_sync_q     <= scko_sync_d;
            sdo_sync_q      <= sdo_sync_d;
            cnv_prev_q      <= cnv_prev_d;
            scko_prev_q     <= scko_prev_d;
            ts_reset_prev_q <= ts_reset_prev_d;
            ts_q            <= ts_d;
            t_q             <= t_d;
            state_q         <= state_d;
            sh_q            <= sh_d;
            bit_cnt_q       <= bit_cnt_d;
            ch_q            <= ch_d;
            overflow_cnt_q  <= overflow_cnt_d;
            err_cnt_q       <= err_cnt_d;
`ifdef LTC233X_FRAME_CRC_EN
            crc_q           <= crc_d;
`endif
        end
    end

    ltc_sync_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (m_tready),
        .rd_data (m_tdata),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign m_tvalid     = !fifo_empty;
    assign overflow_cnt = overflow_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ltc233x_multi_read.sv
// tb_ltc233x_multi_read: directed and randomized frames checked against a queue-based frame model.
module tb_ltc233x_multi_read;
    localparam int N_CH = 2, PKT_BITS = 24, TS_WIDTH = 56, BUF_DEPTH = 8, SYNC = 2;
`ifdef LTC233X_FRAME_CRC_EN
    localparam int WPF = N_CH + 3;
`else
    localparam int WPF = N_CH + 2;
`endif

    logic        clk = 0, reset = 1, enable = 0, ts_reset = 0;
    logic        cnv_in = 0, scko_in = 0, sdo_in = 0, m_tready = 0;
    logic [31:0] m_tdata;
    logic        m_tvalid, busy;
    logic [15:0] overflow_cnt, err_cnt;

    int          errors = 0, checks = 0;
    int          cyc = 0, k = 0, ovf_exp = 0, err_exp = 0;
    bit          active = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    ltc233x_multi_read #(
        .N_CH(N_CH), .PKT_BITS(PKT_BITS), .TS_WIDTH(TS_WIDTH),
        .BUF_DEPTH(BUF_DEPTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ts_reset(ts_reset),
        .cnv_in(cnv_in), .scko_in(scko_in), .sdo_in(sdo_in),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .overflow_cnt(overflow_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    // CRC-16-CCITT of the frame's data bit stream, MSB first
    function automatic logic [15:0] ref_crc(input logic [47:0] s);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 47; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ (((c[15] ^ s[i]) == 1'b1) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Timestamp is 0 in the cycle after the ts_reset edge; cnv is driven gap cycles after the pulse
    task automatic ts_pulse(input int gap);
        ts_reset = 1;
        k = cyc;
        step();
        ts_reset = 0;
        repeat (gap - 1) step();
    endtask

    task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int nedges, input int drop_at);
        logic [55:0] t;
        logic [47:0] s;
        bit          acc;
        s = {p0, p1};
        // cnv is seen SYNC cycles after it is driven and T is latched in that cycle
        t = 56'(cyc - k - 1 + SYNC);
        if (active) err_exp++;
        active = 0;
        acc = enable && ((BUF_DEPTH - exp_q.size()) >= WPF);
        if (enable && !acc) ovf_exp++;
        if (acc) begin
            exp_q.push_back({4'hA, t[27:0]});
            exp_q.push_back({4'hB, t[55:28]});
            if (nedges >= 24) exp_q.push_back({4'hD, 4'd0, p0});
            if (nedges >= 48) exp_q.push_back({4'hD, 4'd1, p1});
`ifdef LTC233X_FRAME_CRC_EN
            if (nedges >= 48) exp_q.push_back({4'hC, 12'h0, ref_crc(s)});
`endif
            active = (nedges < 48);
        end
        cnv_in = 1;
        repeat (4) step();
        cnv_in = 0;
        repeat (2) step();
        chk("busy_start", busy, acc);
        for (int i = 0; i < nedges; i++) begin
            if (i == drop_at) enable = 0;
            sdo_in = s[47-i];
            step();
            scko_in = ~scko_in;
            step();
        end
        repeat (6) step();
        chk("busy_end", busy, acc && (nedges < 48));
        chk("overflow_cnt", overflow_cnt, ovf_exp);
        chk("err_cnt", err_cnt, err_exp);
    endtask

    task automatic drain();
        int          n;
        logic [31:0] w;
        m_tready = 1;
        while (exp_q.size() > 0) begin
            n = 0;
            @(negedge clk);
            while (!m_tvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            w = exp_q.pop_front();
            chk("word_valid", m_tvalid, 1'b1);
            chk("word_data", m_tdata, w);
            if (!m_tvalid) exp_q.delete();
            @(posedge clk);
            #1;
        end
        m_tready = 0;
        @(negedge clk);
        chk("fifo_empty", m_tvalid, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_overflow", overflow_cnt, 16'h0);
        chk("rst_err", err_cnt, 16'h0);
        chk("rst_busy", busy, 1'b0);
        reset = 0;
        enable = 1;
        repeat (3) step();

        // Timestamp 0x123 frame with known packets
        ts_pulse(32'h122);
        run_frame(24'hABCDEF, 24'h012345, 48, -1);
        drain();

        // Back-pressure: fill the buffer, then one frame too many
        repeat (3) run_frame(24'($urandom), 24'($urandom), 48, -1);
        drain();

        // Truncated frame: packet 1 six bits in when cnv returns
        ts_pulse($urandom_range(5, 60));
        run_frame(24'($urandom), 24'($urandom), 30, -1);
        run_frame(24'($urandom), 24'($urandom), 48, -1);
        drain();

        // enable low at cnv blocks the frame; enable dropping mid-frame does not
        enable = 0;
        run_frame(24'($urandom), 24'($urandom), 48, -1);
        drain();
        enable = 1;
        ts_pulse(5);
        run_frame(24'($urandom), 24'($urandom), 48, 10);
        enable = 1;
        drain();

        // All-zero and all-one packets (CRC trailer when enabled)
        run_frame(24'h000000, 24'hFFFFFF, 48, -1);
        drain();

        for (int r = 0; r < 4; r++) begin
            run_frame(24'($urandom), 24'($urandom), 48, $urandom_range(0, 60));
            enable = 1;
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
